// File: rtl/sap_mem_pkg.sv
// Shared widths and sequencer state encoding for the SAP-II memory responder.
// Optional parity (SAP_MEM_PARITY_EN) is handled in the top and RAM core.
package sap_mem_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/sap_ram_core.sv
// Single-port-per-direction RAM: synchronous write, registered read-before-write.
// With SAP_MEM_PARITY_EN the read port also flags odd-parity stored words.
module sap_ram_core #(
    parameter int unsigned AW = 8,
    parameter int unsigned W  = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
`ifdef SAP_MEM_PARITY_EN
    ,
    output logic          rerr
`endif
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [W-1:0] mem [DEPTH];

    // Storage is never reset; contents survive clr.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

`ifdef SAP_MEM_PARITY_EN
    // Even parity over data+parity bit is zero for an intact word.
    always_ff @(posedge clk) begin
        if (!clr) begin
            rerr <= 1'b0;
        end else if (re) begin
            rerr <= ^mem[raddr];
        end else begin
            rerr <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/sap_mem_responder.sv
// SAP-II memory responder: 256x8 RAM on the MAR/W-bus plus a byte-stream program loader.
// Define SAP_MEM_PARITY_EN to store a parity bit per word and expose parity_err.
module sap_mem_responder #(
    parameter int unsigned ADDR_W = sap_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = sap_mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic              ce,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_last,
    output logic              prog_ready,
    output logic              prog_done
`ifdef SAP_MEM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    import sap_mem_pkg::*;

`ifdef SAP_MEM_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned WORD_W = DATA_W + PAR_W;
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ld_we;
    logic              bus_en;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] wr_byte;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    // Sequencer state and pointer registers.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            prog_ready <= 1'b0;
            prog_done  <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            prog_ready <= (state_d == LOAD);
            prog_done  <= (state_d == DONE);
            rd_valid   <= ram_re;
        end
    end

    // Next-state and loader write strobe.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ld_we   = 1'b0;
        case (state_q)
            IDLE: begin
                ptr_d = '0;
                if (prog_mode) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (prog_valid) begin
                    ld_we = 1'b1;
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (prog_last || (ptr_q == PTR_MAX)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!prog_mode) begin
            state_d = IDLE;
            ptr_d   = '0;
        end
    end

    // Bus access only in normal mode; the loader owns the write port otherwise.
    assign bus_en    = (state_q == IDLE) && !prog_mode;
    assign ram_re    = bus_en && ce && clr;
    assign ram_we    = (ld_we || (bus_en && we)) && clr;
    assign ram_waddr = ld_we ? ptr_q : addr;
    assign wr_byte   = ld_we ? prog_data : din;

`ifdef SAP_MEM_PARITY_EN
    assign wr_word = {^wr_byte, wr_byte};
`else
    assign wr_word = wr_byte;
`endif

    sap_ram_core #(
        .AW (ADDR_W),
        .W  (WORD_W)
    ) u_ram (
        .clk   (clk),
        .clr   (clr),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (wr_word),
        .re    (ram_re),
        .raddr (addr),
        .rdata (rd_word)
`ifdef SAP_MEM_PARITY_EN
        ,
        .rerr  (parity_err)
`endif
    );

    assign dout = rd_word[DATA_W-1:0];

endmodule

// File: doc/sap_mem_responder.md
# sap_mem_responder

Responder end of the memory-address path of the SAP-II datapath: a 256 x 8 RAM that takes the address held in the memory address register and services bus reads and writes. It also contains a program-load sequencer that fills the RAM from a byte stream, replacing front-panel switch programming. The block sits between the memory address register output, the W-bus, and the controller's memory enables.

## Interface
- ADDR_W, 8, address width; depth is 2**ADDR_W words.
- DATA_W, 8, word width.
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous reset, active-low; sampled only on the rising edge of clk.
- addr  in  ADDR_W  address from the memory address register output.
- ce  in  1  read enable; reads mem[addr] into dout.
- we  in  1  write enable; writes din to mem[addr].
- din  in  DATA_W  write data from the W-bus.
- dout  out  DATA_W  registered read data.
- rd_valid  out  1  dout was updated on the last edge (one-cycle pulse).
- prog_mode  in  1  selects the program-load sequencer; level-sensitive.
- prog_valid  in  1  prog_data is valid.
- prog_data  in  DATA_W  byte to load.
- prog_last  in  1  marks the final byte; qualified by prog_valid.
- prog_ready  out  1  sequencer accepts a byte this cycle.
- prog_done  out  1  load complete; held high.
- parity_err  out  1  present only with SAP_MEM_PARITY_EN.

## Operation
- Reset (clr=0 at an edge):
  - Outputs: dout=0, rd_valid=0, prog_ready=0, prog_done=0, parity_err=0.
  - Sequencer: state=IDLE, load pointer ptr=0.
  - RAM contents are not cleared.
- Normal mode (state IDLE, prog_mode=0):
  - ce=1: dout <= mem[addr], rd_valid=1 for one cycle.
  - we=1: mem[addr] <= din.
  - ce and we together: write performed; dout returns the OLD word (read-before-write).
  - ce=0: dout holds its last value.
- Sequencer states, one transition per edge:
  - IDLE: prog_mode=1 -> LOAD with ptr=0.
  - LOAD: prog_ready=1. On each edge with prog_valid=1: mem[ptr] <= prog_data, then ptr <= ptr+1.
    - Accepted byte with prog_last=1, or with ptr=2**ADDR_W-1 -> DONE.
    - After the 256th byte, ptr wraps to 0; that byte is never overwritten.
  - DONE: prog_ready=0, prog_done=1, no writes; stays until prog_mode=0.
  - Any state with prog_mode=0 -> IDLE next edge; ptr=0, prog_done=0.
- While state is not IDLE, ce and we are ignored: no reads, no writes, rd_valid=0.
- Reset mid-load: aborts the load; bytes already written stay in RAM.
- All address arithmetic is modulo 2**ADDR_W.

## Timing
- Read latency 1: addr and ce are sampled at edge N; dout is valid after edge N.
- Write latency 1: a read of the same address at edge N+1 returns the new data.
- Load handshake: a byte transfers on an edge where prog_valid and prog_ready are both 1. Back-to-back loads run at 1 byte per cycle.
- prog_ready is registered; it rises the cycle after prog_mode is first sampled high.
- A 256-byte load with prog_valid held high takes 1 cycle to enter LOAD plus 256 cycles. prog_done is high after the 257th edge following prog_mode rise.

## Configuration
- SAP_MEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, computed on both bus writes and loader writes.
  - On a read, parity_err is registered alongside dout: 1 if the stored word and stored parity mismatch, else 0. It pulses with rd_valid.
- SAP_MEM_PARITY_EN undefined: no parity storage and no parity_err port.

## Structure
- Package sap_mem_pkg:
  - ADDR_W and DATA_W defaults.
  - Sequencer state enum: IDLE, LOAD, DONE.
- Sub-module sap_ram_core holds the storage array:
  - One synchronous write port.
  - One synchronous read port with read-before-write behaviour.
  - Word width DATA_W, or DATA_W+1 with parity.
- The top level owns the sequencer and the write-port mux (bus vs loader).

## Test plan
- Reset: clr=0 for 2 cycles -> dout=0x00, rd_valid=0, prog_ready=0, prog_done=0.
- Write/read: we=1, addr=0x32, din=0xA5; next cycle ce=1, addr=0x32 -> one cycle later dout=0xA5, rd_valid=1 for exactly one cycle.
- Same-cycle access: mem[0x10]=0x11; ce=we=1, addr=0x10, din=0x22 -> dout=0x11; a following read -> 0x22.
- Short load: prog_mode=1; bytes 0x01,0x02,0x03 with prog_last on the 3rd -> prog_done=1, prog_ready=0; reads of 0x00..0x02 return 0x01..0x03; mem[0x03] unchanged.
- Full load with wrap: 256 bytes of value = index, no prog_last -> DONE after byte 255; mem[0xFF]=0xFF, mem[0x00]=0x00. Drop prog_mode -> prog_done=0 the next cycle.
- Abort: clr=0 after 5 accepted bytes -> state IDLE, prog_ready=0; mem[0..4] keep the loaded values; ce/we ignored during LOAD and honoured again after reset.
